aes_round_key_scheduler: RTL and testbench

//  Sequencer and round-key store for the byte-serial keyExpansion_8bit datapath. On start it

---
 rtl/aes_pkg.sv | 49 ++++
 rtl/aes_rk_store.sv | 43 ++++
 rtl/aes_round_key_scheduler.sv | 134 +++++++++++++
 tb/tb_aes_round_key_scheduler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and constants for the AES-128 round-key scheduler
package aes_pkg;

  localparam int NROUNDS       = 10;
  localparam int BYTES_PER_RK  = 16;
  localparam logic [7:0] RCON_EN_ALL = 8'hFF;

  localparam logic [3:0] BC_LAST  = 4'(BYTES_PER_RK - 1);
  localparam logic [3:0] TWO_END  = 4'd2;
  localparam logic [3:0] NORM_END = 4'd11;
  localparam logic [3:0] RK_LAST  = 4'(NROUNDS);

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_ONE   = 3'd1,
    ST_TWO   = 3'd2,
    ST_THREE = 3'd3,
    ST_NORM  = 3'd4,
    ST_SHIFT = 3'd5,
    ST_IDLE  = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

  typedef struct packed {
    logic       sel_input;
    logic       sel_sbox;
    logic       sel_last_out;
    logic       sel_bit_out;
    logic [7:0] rcon_en;
  } ke_ctrl_t;

  localparam ke_ctrl_t CTRL_IDLE = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00};

  // Datapath mux/rcon pattern presented while the scheduler sits in a given state.
  function automatic ke_ctrl_t ctrl_for(input state_t s);
    ke_ctrl_t c;
    c = CTRL_IDLE;
    case (s)
      ST_ONE:   c = '{1'b1, 1'b1, 1'b0, 1'b1, RCON_EN_ALL};
      ST_TWO:   c = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
      ST_THREE: c = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
      ST_NORM:  c = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00};
      ST_SHIFT: c = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
      default:  c = CTRL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/aes_rk_store.sv
// rtl/aes_rk_store.sv - 11x128 round-key array with byte write port and MSB-first read shifter
module aes_rk_store
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [3:0] wr_round,
  input  logic [3:0] wr_idx,
  input  logic [7:0] wr_data,
  input  logic       rd_load,
  input  logic [3:0] rd_round,
  input  logic       rd_shift,
  output logic [7:0] rd_byte
);

  logic [127:0] mem [NROUNDS+1];
  logic [127:0] sh;
  logic [6:0]   wr_lo;

  // Byte 0 lands in bits 127:120, so the low bit offset is 8*(15-idx).
  assign wr_lo = {~wr_idx, 3'b000};

  always_ff @(posedge clk) begin
    if (wr_en && (wr_round <= RK_LAST)) begin
      mem[wr_round][wr_lo +: 8] <= wr_data;
    end
  end

  // Shifting in zeros leaves the shifter empty once the 16th byte has gone out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh <= '0;
    end else if (rd_load) begin
      sh <= mem[rd_round];
    end else if (rd_shift) begin
      sh <= {sh[119:0], 8'h00};
    end
  end

  assign rd_byte = sh[127:120];

endmodule

// File: rtl/aes_round_key_scheduler.sv
// rtl/aes_round_key_scheduler.sv - sequences keyExpansion_8bit over 11 rounds and serves stored round keys
module aes_round_key_scheduler
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] key_in,
  output logic [7:0] ke_key_byte,
  input  logic [7:0] ke_round_key,
  output logic       ke_select_input,
  output logic       ke_select_sbox,
  output logic       ke_select_last_out,
  output logic       ke_select_bit_out,
  output logic [7:0] ke_rcon_en,
  output logic [3:0] ke_round,
  output logic       busy,
  output logic       keys_ready,
  input  logic       rk_req,
  input  logic [3:0] rk_round,
  output logic       rk_valid,
  output logic [7:0] rk_byte,
  output logic       rk_last,
  output logic       rk_err
);

  state_t     state;
  state_t     state_n;
  ke_ctrl_t   ctrl;
  logic [3:0] bc;
  logic [3:0] rk_cnt;
  logic       expanding;
  logic       last_round;
  logic       serve_busy;
  logic       start_acc;
  logic       rk_acc;

  assign expanding  = (state != ST_IDLE) && (state != ST_DONE);
  assign last_round = (ke_round == RK_LAST);
  assign serve_busy = rk_valid && !rk_last;
  assign start_acc  = start && ((state == ST_IDLE) || (state == ST_DONE)) && !serve_busy;
  // A start in the same cycle takes precedence, so the request is refused.
  assign rk_acc     = rk_req && keys_ready && (rk_round <= RK_LAST) && !serve_busy && !start_acc;

  always_comb begin
    state_n = state;
    if (start_acc) begin
      state_n = ST_LOAD;
    end else begin
      case (state)
        ST_LOAD:  if (bc == BC_LAST) state_n = ST_ONE;
        ST_ONE:   state_n = ST_TWO;
        ST_TWO:   if (bc == TWO_END) state_n = ST_THREE;
        ST_THREE: state_n = ST_NORM;
        ST_NORM:  if (bc == NORM_END) state_n = ST_SHIFT;
        ST_SHIFT: if (bc == BC_LAST) state_n = last_round ? ST_DONE : ST_ONE;
        default:  state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      ctrl       <= CTRL_IDLE;
      bc         <= 4'd0;
      ke_round   <= 4'd0;
      busy       <= 1'b0;
      keys_ready <= 1'b0;
    end else begin
      state <= state_n;
      ctrl  <= ctrl_for(state_n);
      if (start_acc) begin
        bc         <= 4'd0;
        ke_round   <= 4'd0;
        busy       <= 1'b1;
        keys_ready <= 1'b0;
      end else if (expanding) begin
        bc <= bc + 4'd1;
        if ((bc == BC_LAST) && !last_round) begin
          ke_round <= ke_round + 4'd1;
        end
        if (state_n == ST_DONE) begin
          busy <= 1'b0;
        end
      end else if (state == ST_DONE) begin
        keys_ready <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rk_valid <= 1'b0;
      rk_last  <= 1'b0;
      rk_err   <= 1'b0;
      rk_cnt   <= 4'd0;
    end else begin
      rk_err <= rk_req && !rk_acc;
      if (rk_acc) begin
        rk_valid <= 1'b1;
        rk_last  <= 1'b0;
        rk_cnt   <= 4'd0;
      end else if (rk_valid) begin
        rk_cnt  <= rk_cnt + 4'd1;
        rk_last <= (rk_cnt == BC_LAST - 4'd1);
        if (rk_cnt == BC_LAST) begin
          rk_valid <= 1'b0;
        end
      end
    end
  end

  aes_rk_store u_store (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (expanding),
    .wr_round (ke_round),
    .wr_idx   (bc),
    .wr_data  ((state == ST_LOAD) ? key_in : ke_round_key),
    .rd_load  (rk_acc),
    .rd_round (rk_round),
    .rd_shift (rk_valid),
    .rd_byte  (rk_byte)
  );

  assign ke_key_byte        = (state == ST_LOAD) ? key_in : 8'h00;
  assign ke_select_input    = ctrl.sel_input;
  assign ke_select_sbox     = ctrl.sel_sbox;
  assign ke_select_last_out = ctrl.sel_last_out;
  assign ke_select_bit_out  = ctrl.sel_bit_out;
  assign ke_rcon_en         = ctrl.rcon_en;

endmodule

// File: tb/tb_aes_round_key_scheduler.sv
// tb/tb_aes_round_key_scheduler.sv - self-checking bench for the AES-128 round-key scheduler
module tb_aes_round_key_scheduler;

  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [11:0]  LOAD_CTRL = {4'b0100, 8'h00};

  typedef struct packed {
    logic [4:0]  len;
    logic [11:0] ctrl;
  } phase_t;

  typedef struct packed {
    logic [3:0]   round;
    logic         err;
    logic [127:0] exp;
  } serve_vec_t;

  logic       clk, rst, start, rk_req;
  logic [7:0] key_in, ke_key_byte, ke_round_key, ke_rcon_en, rk_byte;
  logic       ke_select_input, ke_select_sbox, ke_select_last_out, ke_select_bit_out;
  logic [3:0] ke_round, rk_round;
  logic       busy, keys_ready, rk_valid, rk_last, rk_err;

  int n_checks;
  int n_fail;
  logic [127:0] rk_model [11];
  phase_t       phases [5];
  serve_vec_t   vecs [6];
  logic [8:0]   sb_q [$];

  aes_round_key_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in),
    .ke_key_byte(ke_key_byte), .ke_round_key(ke_round_key),
    .ke_select_input(ke_select_input), .ke_select_sbox(ke_select_sbox),
    .ke_select_last_out(ke_select_last_out), .ke_select_bit_out(ke_select_bit_out),
    .ke_rcon_en(ke_rcon_en), .ke_round(ke_round), .busy(busy), .keys_ready(keys_ready),
    .rk_req(rk_req), .rk_round(rk_round), .rk_valid(rk_valid), .rk_byte(rk_byte),
    .rk_last(rk_last), .rk_err(rk_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box from first principles: GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] e;
    inv = 8'h01;
    e = 8'hFE;
    for (int i = 7; i >= 0; i--) begin
      inv = gmul(inv, inv);
      if (e[i]) inv = gmul(inv, x);
    end
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  task automatic build_model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*(3-i) +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_model[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [11:0] exp_ctrl(input int c);
    int o;
    o = c % 16;
    if (c < 16 || c >= 176) return LOAD_CTRL;
    for (int p = 0; p < 5; p++) begin
      if (o < int'(phases[p].len)) return phases[p].ctrl;
      o = o - int'(phases[p].len);
    end
    return 12'hFFF;
  endfunction

  task automatic check_reset(input string name);
    #1;
    check(name,
          {ke_key_byte, ke_select_input, ke_select_sbox, ke_select_last_out, ke_select_bit_out,
           ke_rcon_en, ke_round, busy, keys_ready, rk_valid, rk_byte, rk_last, rk_err},
          {8'h00, 4'b0100, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
  endtask

  always @(negedge clk) begin
    if (rk_valid) begin
      if (sb_q.size() == 0) begin
        check("rk_unexpected_valid", 1'b1, 1'b0);
      end else begin
        check("rk_byte", {rk_last, rk_byte}, sb_q.pop_front());
      end
    end
  end

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check(name, sb_q.size(), 0);
  endtask

  task automatic serve_one(input string name, input logic [3:0] round, input logic err,
                           input logic [127:0] exp);
    @(negedge clk);
    rk_req = 1'b1;
    rk_round = round;
    if (!err) begin
      for (int b = 0; b < 16; b++) sb_q.push_back({(b == 15), exp[8*(15-b) +: 8]});
    end
    @(negedge clk);
    rk_req = 1'b0;
    check({name, "_err"}, rk_err, err);
    wait_drain({name, "_drain"});
  endtask

  // Bench plays the datapath: it presents round key (c/16) byte (c%16) on its own cycle count.
  task automatic run_expansion(input logic [127:0] key, input bit with_req, input int abort_at);
    int rcon_cnt;
    logic [11:0] ec;
    rcon_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    key_in = 8'h00;
    ke_round_key = 8'h00;
    if (with_req) begin
      rk_req = 1'b1;
      rk_round = 4'd1;
    end
    @(posedge clk);
    for (int c = 0; c <= 177; c++) begin
      @(negedge clk);
      start = 1'b0;
      rk_req = 1'b0;
      if (c == abort_at) begin
        rst = 1'b1;
        check_reset("abort_reset");
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      key_in = (c < 16) ? key[8*(15-c) +: 8] : 8'h00;
      ke_round_key = (c >= 16 && c < 176) ? rk_model[c/16][8*(15-(c%16)) +: 8] : 8'h00;
      if (c == 176 && !with_req) begin
        rk_req = 1'b1;
        rk_round = 4'd1;
      end
      #1;
      ec = exp_ctrl(c);
      check($sformatf("ctrl_c%0d", c),
            {ke_select_input, ke_select_sbox, ke_select_last_out, ke_select_bit_out, ke_rcon_en,
             ke_round, busy, keys_ready, ke_key_byte},
            {ec, (c < 176) ? 4'(c/16) : 4'd10, (c < 176), (c >= 177), key_in & {8{c < 16}}});
      if (c == 0 && with_req) check("start_wins_err", rk_err, 1'b1);
      if (c == 177 && !with_req) check("req_before_ready_err", rk_err, 1'b1);
      if (ke_rcon_en == 8'hFF) rcon_cnt++;
    end
    check("rcon_count", rcon_cnt, 10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    clk = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    key_in = 8'h5a;
    ke_round_key = 8'h00;
    rk_req = 1'b0;
    rk_round = 4'd0;

    phases[0] = '{5'd1, {4'b1101, 8'hFF}};
    phases[1] = '{5'd2, {4'b1101, 8'h00}};
    phases[2] = '{5'd1, {4'b1001, 8'h00}};
    phases[3] = '{5'd8, {4'b1011, 8'h00}};
    phases[4] = '{5'd4, {4'b1010, 8'h00}};

    build_model(KEY1);
    vecs[0] = '{4'd1,  1'b0, 128'ha0fafe1788542cb123a339392a6c7605};
    vecs[1] = '{4'd10, 1'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[2] = '{4'd0,  1'b0, KEY1};
    vecs[3] = '{4'd11, 1'b1, 128'h0};
    vecs[4] = '{4'd7,  1'b0, rk_model[7]};
    vecs[5] = '{4'd15, 1'b1, 128'h0};

    repeat (3) @(negedge clk);
    check_reset("reset_state");
    rst = 1'b0;

    serve_one("req_idle", 4'd1, 1'b1, 128'h0);

    run_expansion(KEY1, 1'b0, -1);
    for (int i = 0; i < 6; i++) serve_one($sformatf("vec%0d", i), vecs[i].round, vecs[i].err, vecs[i].exp);

    // Request and start while a serve is running: both must be ignored.
    @(negedge clk);
    rk_req = 1'b1;
    rk_round = 4'd2;
    for (int b = 0; b < 16; b++) sb_q.push_back({(b == 15), rk_model[2][8*(15-b) +: 8]});
    @(negedge clk);
    rk_req = 1'b0;
    check("mid_first_err", rk_err, 1'b0);
    repeat (4) @(negedge clk);
    rk_req = 1'b1;
    rk_round = 4'd3;
    @(negedge clk);
    rk_req = 1'b0;
    check("mid_serve_err", rk_err, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_during_serve", {busy, keys_ready}, 2'b01);
    wait_drain("mid_serve_drain");

    run_expansion(KEY1, 1'b1, 90);
    @(negedge clk);
    check("after_abort", {busy, keys_ready, rk_valid}, 3'b000);

    build_model(128'h0);
    run_expansion(128'h0, 1'b0, -1);
    serve_one("zero_r10", 4'd10, 1'b0, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    serve_one("zero_r0", 4'd0, 1'b0, 128'h0);
    serve_one("zero_r4", 4'd4, 1'b0, rk_model[4]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
